wb_pipe_ram: RTL and testbench

// Parametrised pipelined Wishbone (B4 pipelined) slave RAM; next-generation data/instruction store behind the cpu core.

---
 rtl/wb_pipe_ram.sv | 127 ++++++++++++
 tb/tb_wb_pipe_ram.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_pipe_ram.sv
// rtl/wb_pipe_ram.sv - pipelined Wishbone slave RAM with byte lanes, fixed read latency, stall backpressure and cycle abort.
// Optional feature: define WB_PIPE_RAM_ERR_EN to answer out-of-range word indices with o_wb_err instead of wrapping.
module wb_pipe_ram #(
    parameter int DATA_W          = 32,
    parameter int DEPTH           = 1024,
    parameter int ADDR_W          = 32,
    parameter int LATENCY         = 1,
    parameter int MAX_OUTSTANDING = 2,
    parameter     INIT_FILE       = ""
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_wb_cyc,
    input  logic                i_wb_stb,
    input  logic                i_wb_we,
    input  logic [ADDR_W-1:0]   i_wb_addr,
    input  logic [DATA_W-1:0]   i_wb_data,
    input  logic [DATA_W/8-1:0] i_wb_sel,
    output logic [DATA_W-1:0]   o_wb_data,
    output logic                o_wb_ack,
    output logic                o_wb_stall,
    output logic                o_wb_err
);
    localparam int SEL_W  = DATA_W / 8;
    localparam int BSH    = $clog2(SEL_W);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int PEND_W = $clog2(MAX_OUTSTANDING + 1);

    if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_data_w
        $error("wb_pipe_ram: DATA_W must be a non-zero multiple of 8");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("wb_pipe_ram: DEPTH must be a power of two >= 2");
    end
    if (ADDR_W <= BSH + IDX_W) begin : g_bad_addr_w
        $error("wb_pipe_ram: ADDR_W too narrow for DEPTH");
    end
    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("wb_pipe_ram: LATENCY must be 1..4");
    end
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > LATENCY + 1) begin : g_bad_outstanding
        $error("wb_pipe_ram: MAX_OUTSTANDING must be 1..LATENCY+1");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    logic [IDX_W-1:0]  idx;
    logic              req_err;
    logic              accept;
    logic              wr_en;
    logic              resp_done;
    logic [PEND_W-1:0] pending;
    logic [LATENCY-1:0] vld_q;
    logic [LATENCY-1:0] err_q;
    logic [DATA_W-1:0] data_q [LATENCY];
    logic              unused_addr;

    // Byte-offset bits never select anything; the high bits only matter when errors are enabled.
    assign unused_addr = ^i_wb_addr;
    assign idx         = i_wb_addr[BSH +: IDX_W];

`ifdef WB_PIPE_RAM_ERR_EN
    assign req_err = |i_wb_addr[ADDR_W-1:BSH+IDX_W];
`else
    assign req_err = 1'b0;
`endif

    assign o_wb_stall = (pending == PEND_W'(MAX_OUTSTANDING));
    // Reset gating keeps the RAM untouched while the bus side is held in reset.
    assign accept     = i_wb_cyc & i_wb_stb & ~o_wb_stall & i_reset_n;
    assign wr_en      = accept & i_wb_we & ~req_err;
    assign resp_done  = vld_q[LATENCY-1] | err_q[LATENCY-1];

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            for (int b = 0; b < SEL_W; b++) begin
                if (i_wb_sel[b]) begin
                    mem[idx][b*8 +: 8] <= i_wb_data[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            vld_q   <= '0;
            err_q   <= '0;
            pending <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else if (!i_wb_cyc) begin
            // Abort: every response still in the pipe is dropped.
            vld_q   <= '0;
            err_q   <= '0;
            pending <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            vld_q[0]  <= accept & ~req_err;
            err_q[0]  <= accept & req_err;
            // Stage data is zero unless it carries read data, so the output needs no gating.
            data_q[0] <= (accept && !i_wb_we && !req_err) ? mem[idx] : '0;
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i]  <= vld_q[i-1];
                err_q[i]  <= err_q[i-1];
                data_q[i] <= data_q[i-1];
            end
            case ({accept, resp_done})
                2'b10:   pending <= pending + PEND_W'(1);
                2'b01:   pending <= pending - PEND_W'(1);
                default: pending <= pending;
            endcase
        end
    end

    assign o_wb_ack  = vld_q[LATENCY-1];
    assign o_wb_data = data_q[LATENCY-1];

`ifdef WB_PIPE_RAM_ERR_EN
    assign o_wb_err = err_q[LATENCY-1];
`else
    assign o_wb_err = 1'b0;
`endif

endmodule

// File: tb/tb_wb_pipe_ram.sv
// tb/tb_wb_pipe_ram.sv - randomized bench for wb_pipe_ram against a queue-based response model.
module tb_wb_pipe_ram;
    localparam int DW    = 32;
    localparam int DEPTH = 64;
    localparam int AW    = 16;
    localparam int LAT   = 3;
    localparam int MO    = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wb_cyc, wb_stb, wb_we;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_wdata;
    logic [3:0]    wb_sel;
    logic [DW-1:0] wb_rdata;
    logic          wb_ack, wb_stall, wb_err;

    always #5 clk = ~clk;

    wb_pipe_ram #(
        .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .LATENCY(LAT), .MAX_OUTSTANDING(MO), .INIT_FILE("")
    ) u_dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb), .i_wb_we(wb_we),
        .i_wb_addr(wb_addr), .i_wb_data(wb_wdata), .i_wb_sel(wb_sel),
        .o_wb_data(wb_rdata), .o_wb_ack(wb_ack), .o_wb_stall(wb_stall), .o_wb_err(wb_err)
    );

    typedef struct {
        int          due;
        bit          err;
        bit          rd;
        logic [31:0] data;
    } resp_t;

    resp_t       rq[$];
    logic [31:0] mem_m [DEPTH];
    int          n_edge;
    int          n_checks;
    int          n_errors;
    logic        exp_ack, exp_err, exp_stall, exp_rd;
    logic [31:0] exp_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, want, n_edge);
        end
    endtask

    // Response for a request accepted at edge k is visible right after edge k+LAT-1.
    task automatic model_edge(input logic c, input bit acc, input logic w,
                              input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] sl);
        resp_t r;
        int    widx;
        bit    popped;
        n_edge++;
        if (!c) rq.delete();
        if (acc) begin
            widx = int'(a) / 4;
`ifdef WB_PIPE_RAM_ERR_EN
            r.err = (widx >= DEPTH);
`else
            r.err = 1'b0;
            widx  = widx % DEPTH;
`endif
            r.rd   = !w;
            r.data = (!w && !r.err) ? mem_m[widx] : 32'h0;
            if (w && !r.err) begin
                for (int b = 0; b < 4; b++) begin
                    if (sl[b]) mem_m[widx][b*8 +: 8] = d[b*8 +: 8];
                end
            end
            r.due = n_edge + LAT - 1;
            rq.push_back(r);
        end
        exp_ack = 1'b0; exp_err = 1'b0; exp_data = 32'h0; exp_rd = 1'b0; popped = 1'b0;
        if (rq.size() > 0 && rq[0].due == n_edge) begin
            r = rq.pop_front();
            exp_ack  = !r.err;
            exp_err  = r.err;
            exp_rd   = r.rd;
            exp_data = r.data;
            popped   = 1'b1;
        end
        exp_stall = ((rq.size() + int'(popped)) == MO);
    endtask

    task automatic step(input logic c, input logic s, input logic w, input logic [AW-1:0] a,
                        input logic [31:0] d, input logic [3:0] sl, output bit acc);
        check("ack", wb_ack, exp_ack);
        check("err", wb_err, exp_err);
        check("stall", wb_stall, exp_stall);
        if (!(exp_ack && !exp_rd)) check("rdata", wb_rdata, exp_data);
        wb_cyc = c; wb_stb = s; wb_we = w; wb_addr = a; wb_wdata = d; wb_sel = sl;
        acc = c && s && !exp_stall;
        @(posedge clk);
        model_edge(c, acc, w, a, d, sl);
        @(negedge clk);
    endtask

    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] sl);
        bit acc;
        int tries = 0;
        do begin
            step(1'b1, 1'b1, w, a, d, sl, acc);
            tries++;
        end while (!acc && tries < 20);
        check("issue_accepted", 32'(acc), 32'h1);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, '0, 32'h0, 4'h0, acc);
    endtask

    task automatic wait_resp(input string tag, input bit want_err, input logic [31:0] want);
        bit seen = 1'b0;
        bit acc;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (wb_ack === 1'b1 || wb_err === 1'b1) begin
                seen = 1'b1;
                check({tag, "_ack"}, wb_ack, !want_err);
                check({tag, "_err"}, wb_err, want_err);
                check({tag, "_data"}, wb_rdata, want);
            end
            step(1'b1, 1'b0, 1'b0, '0, 32'h0, 4'h0, acc);
        end
        check({tag, "_seen"}, 32'(seen), 32'h1);
    endtask

    task automatic reset_check(input string tag);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = '0; wb_wdata = '0; wb_sel = 4'hF;
        #2 rst_n = 1'b0;
        #1;
        check({tag, "_ack"}, wb_ack, 1'b0);
        check({tag, "_err"}, wb_err, 1'b0);
        check({tag, "_stall"}, wb_stall, 1'b0);
        check({tag, "_data"}, wb_rdata, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check({tag, "_hold_ack"}, wb_ack, 1'b0);
        check({tag, "_hold_stall"}, wb_stall, 1'b0);
        rst_n = 1'b1;
        wb_cyc = 1'b0; wb_stb = 1'b0;
        rq.delete();
        exp_ack = 1'b0; exp_err = 1'b0; exp_stall = 1'b0; exp_rd = 1'b0; exp_data = 32'h0;
    endtask

    initial begin
        bit          acc;
        int          cnt;
        logic        c, s, w;
        logic [AW-1:0] a;
        n_edge = 0; n_checks = 0; n_errors = 0;
        rst_n = 1'b1;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_addr = '0; wb_wdata = '0; wb_sel = '0;
        @(negedge clk);
        reset_check("reset");

        for (int i = 0; i < DEPTH; i++) issue(1'b1, AW'(i * 4), $urandom, 4'hF);
        idle(6);

        issue(1'b1, 16'h0010, 32'hAABBCCDD, 4'hF);
        issue(1'b1, 16'h0010, 32'h11223344, 4'h5);
        idle(6);
        issue(1'b0, 16'h0010, 32'h0, 4'h0);
        wait_resp("lanes", 1'b0, 32'hAA22CC44);

        idle(6);
        issue(1'b1, 16'h0014, 32'h5A5A5A5A, 4'h0);
        idle(6);
        issue(1'b0, 16'h0014, 32'h0, 4'h0);
        wait_resp("sel0", 1'b0, mem_m[5]);

        idle(6);
        issue(1'b0, 16'h0020, 32'h0, 4'h0);
        issue(1'b0, 16'h0024, 32'h0, 4'h0);
        step(1'b0, 1'b0, 1'b0, '0, 32'h0, 4'h0, acc);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (wb_ack === 1'b1 || wb_err === 1'b1) cnt++;
            step(1'b1, 1'b0, 1'b0, '0, 32'h0, 4'h0, acc);
        end
        check("abort_no_resp", cnt, 0);
        issue(1'b0, 16'h0028, 32'h0, 4'h0);
        wait_resp("post_abort", 1'b0, mem_m[10]);

        idle(6);
        issue(1'b0, AW'(DEPTH * 4), 32'h0, 4'h0);
`ifdef WB_PIPE_RAM_ERR_EN
        wait_resp("oor", 1'b1, 32'h0);
`else
        wait_resp("oor", 1'b0, mem_m[0]);
`endif

        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) reset_check("mid_reset");
            c = ($urandom_range(0, 99) >= 3);
            s = ($urandom_range(0, 99) < 70);
            w = 1'(($urandom_range(0, 1)));
            a = AW'($urandom_range(0, DEPTH + 3) * 4 + $urandom_range(0, 3));
            step(c, s, w, a, $urandom, 4'($urandom_range(0, 15)), acc);
        end
        idle(6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
